// File: rtl/paddle_centroid.sv
// Per-frame centroid of two mask colors: accumulates count/sumX/sumY, then divides sequentially.
// Latency: results and result_valid 113 clocks after the edge sampling the frame's last pixel.
// Backpressure: none; pixels are always accepted, a frame ending while busy is dropped with overrun.
module paddle_centroid #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int MIN_PIXELS   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [1:0]  colorCode,
    input  logic [10:0] row,
    input  logic [11:0] col,
    output logic [11:0] cx1,
    output logic [10:0] cy1,
    output logic        found1,
    output logic [11:0] cx2,
    output logic [10:0] cy2,
    output logic        found2,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {ACCUM, DIVIDE, PUBLISH} state_t;

    state_t state, next_state;

    logic        accepted, is_last, add1, add2;
    logic [18:0] cnt1, cnt2, cnt1_nxt, cnt2_nxt;
    logic [27:0] sx1, sy1, sx2, sy2;
    logic [27:0] sx1_nxt, sy1_nxt, sx2_nxt, sy2_nxt;
    logic [18:0] snap_cnt1, snap_cnt2;
    logic [27:0] snap_sy1, snap_sx2, snap_sy2;

    logic [27:0] dq, q_nxt, next_dividend;
    logic [18:0] rem, rem_nxt, divisor;
    logic [19:0] rem_sh;
    logic        sub_ok;
    logic [4:0]  bit_cnt;
    logic [1:0]  div_idx;
    logic        last_step;
    logic [11:0] q_x1, q_x2;
    logic [10:0] q_y1, q_y2;
    logic        snap_found1, snap_found2;

    assign accepted = in_valid && (row < 11'(FRAME_HEIGHT)) && (col < 12'(LINE_WIDTH));
    assign is_last  = accepted && (row == 11'(FRAME_HEIGHT - 1)) && (col == 12'(LINE_WIDTH - 1));
    assign add1     = accepted && (colorCode == 2'b01);
    assign add2     = accepted && (colorCode == 2'b10);

    assign cnt1_nxt = cnt1 + 19'(add1);
    assign sx1_nxt  = sx1 + (add1 ? 28'(col) : 28'd0);
    assign sy1_nxt  = sy1 + (add1 ? 28'(row) : 28'd0);
    assign cnt2_nxt = cnt2 + 19'(add2);
    assign sx2_nxt  = sx2 + (add2 ? 28'(col) : 28'd0);
    assign sy2_nxt  = sy2 + (add2 ? 28'(row) : 28'd0);

    // Accumulation never stalls; the last pixel's contribution goes into the snapshot, not the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt1 <= '0; sx1 <= '0; sy1 <= '0;
            cnt2 <= '0; sx2 <= '0; sy2 <= '0;
        end else if (is_last) begin
            cnt1 <= '0; sx1 <= '0; sy1 <= '0;
            cnt2 <= '0; sx2 <= '0; sy2 <= '0;
        end else begin
            cnt1 <= cnt1_nxt; sx1 <= sx1_nxt; sy1 <= sy1_nxt;
            cnt2 <= cnt2_nxt; sx2 <= sx2_nxt; sy2 <= sy2_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_cnt1 <= '0; snap_sy1 <= '0;
            snap_cnt2 <= '0; snap_sx2 <= '0; snap_sy2 <= '0;
        end else if (is_last && state == ACCUM) begin
            snap_cnt1 <= cnt1_nxt; snap_sy1 <= sy1_nxt;
            snap_cnt2 <= cnt2_nxt; snap_sx2 <= sx2_nxt; snap_sy2 <= sy2_nxt;
        end
    end

    // Restoring divider: dq shifts the dividend out the top while quotient bits enter at the bottom.
    assign divisor   = div_idx[1] ? snap_cnt2 : snap_cnt1;
    assign rem_sh    = {rem, dq[27]};
    assign sub_ok    = rem_sh >= {1'b0, divisor};
    assign rem_nxt   = sub_ok ? (rem_sh[18:0] - divisor) : rem_sh[18:0];
    assign q_nxt     = {dq[26:0], sub_ok};
    assign last_step = (state == DIVIDE) && (bit_cnt == 5'd27);

    always_comb begin
        next_dividend = '0;
        case (div_idx)
            2'd0:    next_dividend = snap_sy1;
            2'd1:    next_dividend = snap_sx2;
            2'd2:    next_dividend = snap_sy2;
            default: next_dividend = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dq <= '0; rem <= '0; bit_cnt <= '0; div_idx <= '0;
            q_x1 <= '0; q_y1 <= '0; q_x2 <= '0; q_y2 <= '0;
        end else if (state == ACCUM && is_last) begin
            dq <= sx1_nxt; rem <= '0; bit_cnt <= '0; div_idx <= '0;
        end else if (state == DIVIDE) begin
            if (bit_cnt == 5'd27) begin
                case (div_idx)
                    2'd0:    q_x1 <= q_nxt[11:0];
                    2'd1:    q_y1 <= q_nxt[10:0];
                    2'd2:    q_x2 <= q_nxt[11:0];
                    default: q_y2 <= q_nxt[10:0];
                endcase
                dq      <= next_dividend;
                rem     <= '0;
                bit_cnt <= '0;
                div_idx <= div_idx + 2'd1;
            end else begin
                dq      <= q_nxt;
                rem     <= rem_nxt;
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (is_last) next_state = DIVIDE;
            DIVIDE:  if (last_step && div_idx == 2'd3) next_state = PUBLISH;
            PUBLISH: next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    assign busy        = (state != ACCUM);
    assign snap_found1 = snap_cnt1 >= 19'(MIN_PIXELS);
    assign snap_found2 = snap_cnt2 >= 19'(MIN_PIXELS);

    // Undetected colors keep their last centroid so the overlay does not jump to the origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx1 <= '0; cy1 <= '0; found1 <= 1'b0;
            cx2 <= '0; cy2 <= '0; found2 <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= (state == PUBLISH);
            overrun      <= is_last && (state != ACCUM);
            if (state == PUBLISH) begin
                found1 <= snap_found1;
                found2 <= snap_found2;
                if (snap_found1) begin
                    cx1 <= q_x1;
                    cy1 <= q_y1;
                end
                if (snap_found2) begin
                    cx2 <= q_x2;
                    cy2 <= q_y2;
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_centroid.sv
// Directed frames with a scoreboard model of per-color sums; results checked when result_valid pulses.
module tb_paddle_centroid;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  colorCode;
    logic [10:0] row;
    logic [11:0] col;
    logic [11:0] cx1, cx2;
    logic [10:0] cy1, cy2;
    logic        found1, found2, result_valid, busy, overrun;

    paddle_centroid dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .colorCode(colorCode),
        .row(row), .col(col),
        .cx1(cx1), .cy1(cy1), .found1(found1),
        .cx2(cx2), .cy2(cy2), .found2(found2),
        .result_valid(result_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          due;
        logic        f1, f2;
        logic [11:0] cx1, cx2;
        logic [10:0] cy1, cy2;
    } exp_t;

    exp_t sb[$];

    int          m_cnt1, m_sx1, m_sy1, m_cnt2, m_sx2, m_sy2;
    logic [11:0] p_cx1, p_cx2;
    logic [10:0] p_cy1, p_cy2;
    int          busy_due = 0;
    int          ovr_due  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_cnt1 = 0; m_sx1 = 0; m_sy1 = 0;
        m_cnt2 = 0; m_sx2 = 0; m_sy2 = 0;
    endtask

    task automatic model_last();
        exp_t e;
        if (cyc < busy_due) begin
            ovr_due = cyc + 1;
        end else begin
            e.due = cyc + 114;
            e.f1  = (m_cnt1 >= 64);
            e.f2  = (m_cnt2 >= 64);
            if (e.f1) begin
                p_cx1 = 12'(m_sx1 / m_cnt1);
                p_cy1 = 11'(m_sy1 / m_cnt1);
            end
            if (e.f2) begin
                p_cx2 = 12'(m_sx2 / m_cnt2);
                p_cy2 = 11'(m_sy2 / m_cnt2);
            end
            e.cx1 = p_cx1; e.cy1 = p_cy1;
            e.cx2 = p_cx2; e.cy2 = p_cy2;
            sb.push_back(e);
            busy_due = cyc + 114;
        end
        model_clear();
    endtask

    task automatic px(input logic [1:0] code, input int r, input int c);
        @(negedge clk);
        in_valid  = 1'b1;
        colorCode = code;
        row       = 11'(r);
        col       = 12'(c);
        if (r < 480 && c < 640) begin
            if (code == 2'b01) begin m_cnt1++; m_sx1 += c; m_sy1 += r; end
            if (code == 2'b10) begin m_cnt2++; m_sx2 += c; m_sy2 += r; end
            if (r == 479 && c == 639) model_last();
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic block(input logic [1:0] code, input int r0, input int c0,
                         input int h, input int w, input int maxn);
        int n = 0;
        for (int r = r0; r < r0 + h; r++)
            for (int c = c0; c < c0 + w; c++)
                if (n < maxn) begin
                    px(code, r, c);
                    n++;
                end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cx1"}, cx1, 0);
        chk({tag, "_cy1"}, cy1, 0);
        chk({tag, "_found1"}, found1, 0);
        chk({tag, "_cx2"}, cx2, 0);
        chk({tag, "_cy2"}, cy2, 0);
        chk({tag, "_found2"}, found2, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        model_clear();
        p_cx1 = '0; p_cy1 = '0; p_cx2 = '0; p_cy2 = '0;
        busy_due = 0;
        ovr_due  = -1;
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard consumer: every result_valid must match the oldest expected frame at its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result_valid", result_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("found1", found1, e.f1);
                    chk("cx1", cx1, e.cx1);
                    chk("cy1", cy1, e.cy1);
                    chk("found2", found2, e.f2);
                    chk("cx2", cx2, e.cx2);
                    chk("cy2", cy2, e.cy2);
                    chk("busy_after_publish", busy, 0);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("result_timeout", result_valid, 1);
                void'(sb.pop_front());
            end
            if (overrun || cyc == ovr_due)
                chk("overrun", overrun, (cyc == ovr_due));
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        colorCode = '0;
        row       = '0;
        col       = '0;
        model_clear();
        p_cx1 = '0; p_cy1 = '0; p_cx2 = '0; p_cy2 = '0;
        #2 check_zero("init");
        do_reset();

        // 8x8 color1 block
        block(2'b01, 200, 100, 8, 8, 64);
        px(2'b00, 479, 639);
        chk("busy_after_e0", busy, 1);
        wait_done();
        chk("s1_cx1", cx1, 103);
        chk("s1_cy1", cy1, 203);
        chk("s1_found1", found1, 1);
        chk("s1_found2", found2, 0);
        chk("s1_cx2", cx2, 0);
        chk("s1_cy2", cy2, 0);

        // 63 pixels: one short of detection, previous centroid held
        block(2'b01, 300, 300, 8, 8, 63);
        px(2'b00, 479, 639);
        wait_done();
        chk("s2_found1", found1, 0);
        chk("s2_cx1", cx1, 103);
        chk("s2_cy1", cy1, 203);

        // two full lines of color2 ending on the last pixel
        block(2'b10, 478, 0, 2, 640, 1280);
        wait_done();
        chk("s3_cx2", cx2, 319);
        chk("s3_cy2", cy2, 478);
        chk("s3_found2", found2, 1);
        chk("s3_found1", found1, 0);

        // back-to-back: next frame starts the cycle after the last pixel
        block(2'b01, 200, 100, 8, 8, 64);
        px(2'b00, 479, 639);
        block(2'b01, 0, 10, 480, 1, 480);
        px(2'b00, 479, 639);
        wait_done();
        chk("s4_cx1", cx1, 10);
        chk("s4_cy1", cy1, 239);

        // reserved code and out-of-range color1 pixels, then a second last pixel at E0+50
        block(2'b11, 0, 0, 4, 4, 16);
        px(2'b01, 480, 5);
        px(2'b01, 5, 700);
        px(2'b11, 479, 639);
        repeat (49) @(posedge clk);
        px(2'b01, 479, 639);
        wait_done();
        chk("s5_found1", found1, 0);
        chk("s5_found2", found2, 0);
        chk("s5_cx1", cx1, 10);
        chk("s5_cx2", cx2, 319);

        // reset 40 cycles into the divide, then a clean frame
        block(2'b01, 200, 100, 8, 8, 64);
        px(2'b00, 479, 639);
        repeat (39) @(posedge clk);
        do_reset();
        repeat (200) @(negedge clk);
        block(2'b01, 200, 100, 8, 8, 64);
        px(2'b00, 479, 639);
        wait_done();
        chk("s6_cx1", cx1, 103);
        chk("s6_cy1", cy1, 203);
        chk("s6_found1", found1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/paddle_centroid.md
# paddle_centroid

Per-frame localizer for the two tracked paddle colors, directly downstream of the denoised two-color mask in the paddle localization pipeline. Consumes one 2-bit color code per valid pixel with its row/column, accumulates per-color pixel count and coordinate sums over a 640x480 frame, then runs a shared sequential divider to produce the integer centroid of each color. Results feed the game-logic/overlay stage once per frame; accumulation of the next frame proceeds while division runs.

## Interface

- LINE_WIDTH, 640, active pixels per line
- FRAME_HEIGHT, 480, active lines per frame
- MIN_PIXELS, 64, minimum per-color count for a valid detection
- clk  input  1  pipeline clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  colorCode/row/col qualify this cycle
- colorCode  input  2  00 none, 01 color1, 10 color2, 11 reserved (treated as none)
- row  input  11  pixel row of current sample
- col  input  12  pixel column of current sample
- cx1, cy1  output  12, 11  color1 centroid column/row
- found1  output  1  color1 count >= MIN_PIXELS in last completed frame
- cx2, cy2  output  12, 11  color2 centroid column/row
- found2  output  1  color2 detection flag
- result_valid  output  1  one-cycle pulse when all result outputs update
- busy  output  1  high while divider runs
- overrun  output  1  one-cycle pulse when a frame end is dropped

## Operation

- Accumulators per color: count 19 bits, sumX 28 bits, sumY 28 bits (full frame of one color: 307200, sumX 98150400 — no overflow).
- Pixel accepted only if in_valid and row < FRAME_HEIGHT and col < LINE_WIDTH; otherwise ignored. Code 01 adds to color1, 10 to color2; 00/11 add nothing.
- Last pixel = accepted pixel with row == FRAME_HEIGHT-1 and col == LINE_WIDTH-1 (any code).
- FSM states: ACCUM, DIVIDE, PUBLISH.
  - ACCUM: on last pixel, snapshot = accumulators plus that pixel's contribution; accumulators clear to 0 same edge; go DIVIDE.
  - DIVIDE: four divisions in fixed order sumX1/count1, sumY1/count1, sumX2/count2, sumY2/count2; restoring divider, one quotient bit per cycle, 28 cycles each. Division with count < MIN_PIXELS still spends 28 cycles, result discarded (no divide-by-zero). Quotient truncated; low 12 (x) / 11 (y) bits kept.
  - PUBLISH: one cycle; load outputs, pulse result_valid, return ACCUM.
- found=0: that color's cx/cy hold previous values.
- Accumulation continues in every state; pixels arriving during DIVIDE/PUBLISH belong to the next frame.
- Last pixel while not in ACCUM: pixel accumulated, accumulators cleared (frame discarded), overrun pulses, division in progress unaffected.

## Timing

- Reset: all outputs 0, accumulators/snapshot 0, state ACCUM.
- Edge E0 samples last pixel. busy high from cycle after E0 through E112 (112 divide cycles). Outputs and result_valid update at E113; result_valid high exactly one cycle; busy low after E113. Latency fixed at 113 clocks regardless of found flags.
- Outputs stable between result_valid pulses.
- Reset asserted mid-DIVIDE: immediate return to reset values; no result_valid for that frame; next full frame produces normal result.
- overrun registered, asserted the cycle after the offending edge.

## Test plan

- Color1 8x8 block cols 100-107, rows 200-207, rest 00, one frame -> result_valid 113 cycles after last pixel; cx1=103, cy1=203, found1=1, found2=0, cx2=cy2=0.
- Color1 block of 63 pixels after prior frame with cx1=103 -> found1=0, cx1/cy1 still 103/203.
- Entire frame color2 -> count2=307200, cx2=319, cy2=239, found2=1, found1=0.
- Back-to-back frames, frame 2 has color1 single column col=10 rows 0-479 starting immediately after frame 1 last pixel -> frame 1 result unaffected; frame 2 cx1=10, cy1=239.
- Code 11 everywhere plus color1 pixels at row=480 and col=700 -> found1=found2=0; second last pixel injected 50 cycles after E0 -> overrun pulse, first frame's result_valid still at E113.
- Reset pulse at E0+40 -> all outputs 0, no result_valid; following clean frame as scenario 1 -> cx1=103, cy1=203.
